// File: rtl/fetch_seq.sv
// Fetch sequencer: selects the next PC, drives IFU write enable and IF/ID flush,
// and tracks whether the core is running an exception handler.
module fetch_seq #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      F_pc,
  input  logic             D_branch,
  input  logic             D_redirect,
  input  logic [31:0]      D_target,
  input  logic             D_eret,
  input  logic [31:0]      EPC,
  input  logic             Req,
  output logic [31:0]      npc,
  output logic             pc_en,
  output logic             FD_flush,
  output logic             F_bd,
  output logic             in_handler,
  output logic [CNT_W-1:0] exc_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    HANDLER = 2'b01
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The IFU owns the PC itself; these only reject nonsensical configurations.
  generate
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("fetch_seq: RESET_PC must be word aligned");
    end
    if (EXC_ENTRY[1:0] != 2'b00) begin : g_bad_exc_entry
      $error("fetch_seq: EXC_ENTRY must be word aligned");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("fetch_seq: CNT_W must be at least 1");
    end
  endgenerate

  state_t           state_reg;
  logic             in_handler_reg;
  logic [CNT_W-1:0] exc_cnt_reg;
  logic [31:0]      npc_next;

  always_comb begin
    npc_next = F_pc + 32'd4;
    if (Req) begin
      npc_next = EXC_ENTRY;
    end else if (D_eret) begin
      npc_next = EPC + 32'd4;
    end else if (D_redirect) begin
      npc_next = D_target;
    end
  end

  // Pipeline controls are forced quiet while reset is held; npc still tracks its inputs.
  assign npc      = npc_next;
  assign pc_en    = reset & (Req | ~stall);
  assign FD_flush = reset & Req;
  assign F_bd     = reset & D_branch & ~Req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= RUN;
      in_handler_reg <= 1'b0;
      exc_cnt_reg    <= '0;
    end else begin
      if (Req && (exc_cnt_reg != '1)) begin
        exc_cnt_reg <= exc_cnt_reg + CNT_ONE;
      end
      case (state_reg)
        RUN: begin
          if (Req) begin
            state_reg      <= HANDLER;
            in_handler_reg <= 1'b1;
          end
        end
        HANDLER: begin
          // A stalled eret waits in HANDLER; a new Req always keeps us here.
          if (!Req && D_eret && !stall) begin
            state_reg      <= RUN;
            in_handler_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= RUN;
          in_handler_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_handler = in_handler_reg;
  assign exc_cnt    = exc_cnt_reg;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: directed scenarios then randomized traffic,
// checked against a cycle-level behavioural model.
module tb_fetch_seq;

  localparam logic [31:0] EXC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, stall, D_branch, D_redirect, D_eret, Req;
  logic [31:0] F_pc, D_target, EPC;
  logic [31:0] npc;
  logic        pc_en, FD_flush, F_bd, in_handler;
  logic [7:0]  exc_cnt;

  fetch_seq #(.RESET_PC(32'h0000_3000), .EXC_ENTRY(EXC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .F_pc(F_pc),
    .D_branch(D_branch), .D_redirect(D_redirect), .D_target(D_target),
    .D_eret(D_eret), .EPC(EPC), .Req(Req),
    .npc(npc), .pc_en(pc_en), .FD_flush(FD_flush), .F_bd(F_bd),
    .in_handler(in_handler), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] npc;
    logic        pc_en;
    logic        flush;
    logic        bd;
    logic        inh;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   txn_id   = 0;

  // Reference model: "in handler" flag and exception count.
  bit   m_inh;
  int   m_cnt;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL txn %0d %s: got %h expected %h", id, name, act, exp);
  endtask

  task automatic drive(input bit rst_n, input bit st, input logic [31:0] fpc,
                       input bit br, input bit rd, input logic [31:0] tgt,
                       input bit er, input logic [31:0] epc, input bit rq);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_n; stall = st; F_pc = fpc; D_branch = br; D_redirect = rd;
    D_target = tgt; D_eret = er; EPC = epc; Req = rq;
    e.id    = txn_id++;
    e.npc   = rq ? EXC : er ? epc + 32'd4 : rd ? tgt : fpc + 32'd4;
    e.pc_en = rst_n && (rq || !st);
    e.flush = rst_n && rq;
    e.bd    = rst_n && br && !rq;
    e.inh   = m_inh;
    e.cnt   = 8'(m_cnt);
    q.push_back(e);
    if (!rst_n) begin
      m_inh = 0; m_cnt = 0;
    end else if (rq) begin
      m_inh = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end else if (m_inh && er && !st) begin
      m_inh = 0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        $display("txn %0d: npc=%h pc_en=%b flush=%b bd=%b inh=%b cnt=%0d", e.id, npc, pc_en,
                 FD_flush, F_bd, in_handler, exc_cnt);
        chk("npc", e.id, npc, e.npc);
        chk("pc_en", e.id, 32'(pc_en), 32'(e.pc_en));
        chk("FD_flush", e.id, 32'(FD_flush), 32'(e.flush));
        chk("F_bd", e.id, 32'(F_bd), 32'(e.bd));
        chk("in_handler", e.id, 32'(in_handler), 32'(e.inh));
        chk("exc_cnt", e.id, 32'(exc_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stimulus
    reset = 0; stall = 0; F_pc = 32'h3000; D_branch = 0; D_redirect = 0;
    D_target = 0; D_eret = 0; EPC = 0; Req = 0;
    m_inh = 0; m_cnt = 0;
    @(posedge clk);  // establish a known state before checking
    // reset held: controls quiet, npc still follows selection
    drive(0, 0, 32'h3000, 1, 0, 0, 0, 0, 1);
    // sequential fetch
    drive(1, 0, 32'h3000, 0, 0, 0, 0, 0, 0);
    // taken branch, then same under stall
    drive(1, 0, 32'h3000, 1, 1, 32'h3100, 0, 0, 0);
    drive(1, 1, 32'h3000, 1, 1, 32'h3100, 0, 0, 0);
    // exception under stall, then observe HANDLER
    drive(1, 1, 32'h3004, 1, 1, 32'h3100, 0, 0, 1);
    drive(1, 0, 32'h4180, 0, 0, 0, 0, 0, 0);
    // stalled eret for two cycles, then released
    drive(1, 1, 32'h4184, 0, 0, 0, 1, 32'h3040, 0);
    drive(1, 1, 32'h4184, 0, 0, 0, 1, 32'h3040, 0);
    drive(1, 0, 32'h4184, 0, 0, 0, 1, 32'h3040, 0);
    drive(1, 0, 32'h3044, 0, 0, 0, 0, 0, 0);
    // eret in RUN redirects but state stays RUN
    drive(1, 0, 32'h3048, 0, 0, 0, 1, 32'h3200, 0);
    // nested Req with eret in HANDLER
    drive(1, 0, 32'h3204, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 32'h4180, 0, 0, 0, 1, 32'h3040, 1);
    drive(1, 0, 32'h4180, 0, 0, 0, 0, 0, 0);
    // PC wrap
    drive(1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0);
    // saturation then reset
    for (int i = 0; i < 256; i++) drive(1, i[0], 32'h4180, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 32'h4180, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 32'h4180, 0, 0, 0, 1, 32'h3040, 1);
    drive(1, 0, 32'h3000, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0),
            $urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, $urandom,
            ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 7) == 0));
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
